// File: rtl/rx_da_filter.sv
// Receive destination-address filter.
// Captures the 6-byte DA from the receive byte stream and computes a CRC-32
// hash bin and per-entry station-address matches. It then issues one
// registered accept/reject strobe per frame.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   S_IDLE    | waiting for a frame start (rx_sof with rx_dv)
//   S_COLLECT | accumulating DA bytes 1..5 (byte 0 taken on entry)
//   S_DONE    | DA complete; further bytes ignored until next sof
module rx_da_filter #(
   parameter int HASH_W = 7,
   parameter int N_SA   = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx_dv,
   input  logic                       rx_sof,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_abort,
   input  logic [5:0]                 cfg_mode,
   input  logic [(1<<HASH_W)-1:0]     cfg_hash_tbl,
   input  logic [48*N_SA-1:0]         cfg_sa,
   input  logic [N_SA-1:0]            cfg_sa_en,
   output logic                       flt_valid,
   output logic                       flt_accept,
   output logic                       flt_bcast,
   output logic                       flt_mcast,
   output logic [N_SA-1:0]            flt_sa_hit,
   output logic [HASH_W-1:0]          flt_bin
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [31:0]        crc_q, crc_d;
   logic [N_SA-1:0]    match_q, match_d;
   logic               bcast_q, bcast_d;
   logic               grp_q, grp_d;
   logic               done_q, done_d;

   logic               valid_q;
   logic               accept_q, bc_q, mc_q;
   logic [N_SA-1:0]    hit_q;
   logic [HASH_W-1:0]  bin_q;

   logic               start;
   logic [2:0]         cnt_sel;
   logic [31:0]        crc_step;
   logic [N_SA-1:0]    byte_eq;
   logic [HASH_W-1:0]  bin_w;
   logic               mcast_w, ucast_w, tbl_hit, accept_w;

   // Ethernet CRC-32, eight serial steps, bit 0 of the byte first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
      return c;
   endfunction

   // Per-byte datapath: CRC step and station-address byte compares.
   always_comb begin
      start    = rx_dv & rx_sof;
      cnt_sel  = start ? 3'd0 : cnt_q;
      crc_step = crc_byte(start ? 32'hFFFFFFFF : crc_q, rx_data);
      byte_eq  = '0;
      for (int k = 0; k < N_SA; k++) begin
         byte_eq[k] = (rx_data == cfg_sa[48*k + 40 - 8*int'(cnt_sel) +: 8]);
      end
   end

   // Next-state and collection-register update; sof beats abort, abort beats a byte.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      match_d = match_q;
      bcast_d = bcast_q;
      grp_d   = grp_q;
      done_d  = 1'b0;
      if (start) begin
         state_d = S_COLLECT;
         cnt_d   = 3'd1;
         crc_d   = crc_step;
         match_d = cfg_sa_en & byte_eq;
         bcast_d = (rx_data == 8'hFF);
         grp_d   = rx_data[0];
      end else if (rx_abort) begin
         state_d = S_IDLE;
      end else if (state_q == S_COLLECT && rx_dv) begin
         crc_d   = crc_step;
         match_d = match_q & byte_eq;
         bcast_d = bcast_q & (rx_data == 8'hFF);
         if (cnt_q == 3'd5) begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   // Collection state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         crc_q   <= '1;
         match_q <= '0;
         bcast_q <= 1'b0;
         grp_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         match_q <= match_d;
         bcast_q <= bcast_d;
         grp_q   <= grp_d;
         done_q  <= done_d;
      end
   end

   // Decision from the completed DA; bin is the bit-reversed CRC top bits.
   always_comb begin
      bin_w = '0;
      for (int i = 0; i < HASH_W; i++) begin
         bin_w[i] = crc_q[31-i];
      end
      mcast_w  = grp_q & ~bcast_q;
      ucast_w  = ~grp_q;
      tbl_hit  = cfg_hash_tbl[bin_w];
      accept_w = cfg_mode[0]
               | (bcast_q & cfg_mode[1])
               | (mcast_w & cfg_mode[2])
               | (ucast_w & cfg_mode[3] & (|match_q))
               | (ucast_w & cfg_mode[4] & tbl_hit)
               | (mcast_w & cfg_mode[5] & tbl_hit);
   end

   // Registered strobe and held results, updated only in the decision cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         accept_q <= 1'b0;
         bc_q     <= 1'b0;
         mc_q     <= 1'b0;
         hit_q    <= '0;
         bin_q    <= '0;
      end else begin
         valid_q <= done_q;
         if (done_q) begin
            accept_q <= accept_w;
            bc_q     <= bcast_q;
            mc_q     <= mcast_w;
            hit_q    <= match_q;
            bin_q    <= bin_w;
         end
      end
   end

   assign flt_valid  = valid_q;
   assign flt_accept = accept_q;
   assign flt_bcast  = bc_q;
   assign flt_mcast  = mc_q;
   assign flt_sa_hit = hit_q;
   assign flt_bin    = bin_q;

endmodule

// File: tb/tb_rx_da_filter.sv
// Scoreboard bench for rx_da_filter: stimulus pushes expected decisions,
// a negedge monitor pops and compares whenever flt_valid is seen.
module tb_rx_da_filter;
   localparam int HW = 7;
   localparam int NS = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 rx_dv = 1'b0, rx_sof = 1'b0, rx_abort = 1'b0;
   logic [7:0]           rx_data = '0;
   logic [5:0]           cfg_mode = '0;
   logic [(1<<HW)-1:0]   cfg_hash_tbl = '0;
   logic [48*NS-1:0]     cfg_sa = '0;
   logic [NS-1:0]        cfg_sa_en = '0;
   logic                 flt_valid, flt_accept, flt_bcast, flt_mcast;
   logic [NS-1:0]        flt_sa_hit;
   logic [HW-1:0]        flt_bin;

   typedef struct packed {
      logic          acc;
      logic          bc;
      logic          mc;
      logic [NS-1:0] hit;
      logic [HW-1:0] bin;
      logic [31:0]   cyc;
   } exp_t;

   exp_t q[$];
   exp_t last_exp = '0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   rx_da_filter #(.HASH_W(HW), .N_SA(NS)) dut (
      .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_sof(rx_sof), .rx_data(rx_data),
      .rx_abort(rx_abort), .cfg_mode(cfg_mode), .cfg_hash_tbl(cfg_hash_tbl),
      .cfg_sa(cfg_sa), .cfg_sa_en(cfg_sa_en), .flt_valid(flt_valid),
      .flt_accept(flt_accept), .flt_bcast(flt_bcast), .flt_mcast(flt_mcast),
      .flt_sa_hit(flt_sa_hit), .flt_bin(flt_bin));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [47:0] da);
      exp_t        e;
      logic [31:0] c;
      logic        fb, bc, grp, mc, uc, th;
      c = 32'hFFFFFFFF;
      for (int b = 0; b < 6; b++)
         for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ da[47-8*b-7+i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
         end
      e = '0;
      for (int i = 0; i < HW; i++) e.bin[i] = c[31-i];
      for (int k = 0; k < NS; k++) e.hit[k] = cfg_sa_en[k] && (cfg_sa[48*k +: 48] == da);
      bc  = (da == 48'hFFFF_FFFF_FFFF);
      grp = da[40];
      mc  = grp & ~bc;
      uc  = ~grp;
      th  = cfg_hash_tbl[e.bin];
      e.bc  = bc;
      e.mc  = mc;
      e.acc = cfg_mode[0] | (bc & cfg_mode[1]) | (mc & cfg_mode[2]) |
              (uc & cfg_mode[3] & (|e.hit)) | (uc & cfg_mode[4] & th) | (mc & cfg_mode[5] & th);
      return e;
   endfunction

   // Monitor: every strobe must match the oldest expectation, at the expected cycle.
   always @(negedge clk) begin
      if (rst_n && flt_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency_cycle", cyc, e.cyc);
            chk("accept", flt_accept, e.acc);
            chk("bcast", flt_bcast, e.bc);
            chk("mcast", flt_mcast, e.mc);
            chk("sa_hit", flt_sa_hit, e.hit);
            chk("bin", flt_bin, e.bin);
         end
      end
   end

   task automatic drive_byte(input logic [7:0] b, input logic sof, input logic abt);
      rx_dv = 1'b1; rx_sof = sof; rx_abort = abt; rx_data = b;
      @(posedge clk); #1;
      rx_dv = 1'b0; rx_sof = 1'b0; rx_abort = 1'b0;
   endtask

   task automatic send_bytes(input logic [47:0] da, input int n, input int maxgap);
      for (int b = 0; b < n; b++) begin
         if (b > 0) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
         drive_byte(da[47-8*b -: 8], b == 0, 1'b0);
      end
   endtask

   task automatic push(input exp_t e);
      e.cyc = cyc + 1;
      q.push_back(e);
      last_exp = e;
   endtask

   // Full frame with hand-supplied decision fields; bin comes from the CRC model.
   task automatic frame_hand(input logic [47:0] da, input int maxgap, input logic acc,
                             input logic bc, input logic mc, input logic [NS-1:0] hit);
      exp_t e;
      send_bytes(da, 6, maxgap);
      e = model(da);
      e.acc = acc; e.bc = bc; e.mc = mc; e.hit = hit;
      push(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_held(input string tag);
      @(negedge clk);
      chk({tag, "_valid"}, flt_valid, 1'b0);
      chk({tag, "_accept"}, flt_accept, last_exp.acc);
      chk({tag, "_bcast"}, flt_bcast, last_exp.bc);
      chk({tag, "_mcast"}, flt_mcast, last_exp.mc);
      chk({tag, "_sa_hit"}, flt_sa_hit, last_exp.hit);
      chk({tag, "_bin"}, flt_bin, last_exp.bin);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [47:0] da;
      repeat (3) @(posedge clk);
      #1;
      check_held("reset");
      rst_n = 1'b1;
      idle(2);

      // Broadcast with broadcast enable
      cfg_mode = 6'b000010;
      frame_hand(48'hFFFF_FFFF_FFFF, 0, 1'b1, 1'b1, 1'b0, 2'b00);
      idle(3);

      // Multicast hash, empty and full table
      cfg_mode = 6'b100000;
      cfg_hash_tbl = '0;
      frame_hand(48'h0100_5E00_0001, 0, 1'b0, 1'b0, 1'b1, 2'b00);
      idle(3);
      cfg_hash_tbl = '1;
      frame_hand(48'h0100_5E00_0001, 0, 1'b1, 1'b0, 1'b1, 2'b00);
      idle(3);

      // Perfect match on entry 1
      cfg_hash_tbl = '0;
      cfg_sa = {48'h0011_2233_4455, 48'hAABB_CCDD_EEFF};
      cfg_sa_en = 2'b10;
      cfg_mode = 6'b001000;
      frame_hand(48'h0011_2233_4455, 0, 1'b1, 1'b0, 1'b0, 2'b10);
      idle(3);
      frame_hand(48'h0011_2233_4456, 0, 1'b0, 1'b0, 1'b0, 2'b00);
      idle(3);
      cfg_sa_en = 2'b00;
      frame_hand(48'h0011_2233_4455, 0, 1'b0, 1'b0, 1'b0, 2'b00);
      idle(3);

      // Gapped stream, same decision as the gap-free match
      cfg_sa_en = 2'b10;
      for (int r = 0; r < 3; r++) begin
         frame_hand(48'h0011_2233_4455, 3, 1'b1, 1'b0, 1'b0, 2'b10);
         idle(3);
      end

      // Abort at byte 3, remaining bytes without sof must be ignored
      da = 48'hFFFF_FFFF_FFFF;
      send_bytes(da, 3, 0);
      drive_byte(8'hFF, 1'b0, 1'b1);
      drive_byte(8'hFF, 1'b0, 1'b0);
      drive_byte(8'hFF, 1'b0, 1'b0);
      idle(5);
      check_held("abort");

      // Restart with sof at byte 4: only the second DA is reported
      send_bytes(48'h0011_2233_4455, 4, 0);
      frame_hand(48'h0011_2233_4456, 0, 1'b0, 1'b0, 1'b0, 2'b00);
      idle(3);

      // Reset at byte 2
      send_bytes(48'h0011_2233_4455, 2, 0);
      rst_n = 1'b0;
      drive_byte(8'h22, 1'b0, 1'b0);
      rst_n = 1'b1;
      last_exp = '0;
      check_held("midrst");
      drive_byte(8'h33, 1'b0, 1'b0);
      drive_byte(8'h44, 1'b0, 1'b0);
      drive_byte(8'h55, 1'b0, 1'b0);
      idle(5);

      // Random DAs against the reference model, some back-to-back
      for (int g = 0; g < 30; g++) begin
         idle(2);
         cfg_mode = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) cfg_mode[0] = 1'b0;
         cfg_hash_tbl = {$urandom, $urandom, $urandom, $urandom};
         cfg_sa = {$urandom, $urandom, $urandom};
         cfg_sa[40] = 1'b0;
         cfg_sa_en = 2'($urandom_range(0, 3));
         for (int f = 0; f < 10; f++) begin
            da = {$urandom, $urandom};
            case ($urandom_range(0, 4))
               0: da = 48'hFFFF_FFFF_FFFF;
               1: da[40] = 1'b1;
               2: da[40] = 1'b0;
               3: da = cfg_sa[48*$urandom_range(0, NS-1) +: 48];
               default: ;
            endcase
            send_bytes(da, 6, 2);
            push(model(da));
            if ($urandom_range(0, 1) == 1) idle(1);
         end
      end

      idle(10);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
